// File: rtl/mp_add_seq16.sv
// ---------------------------------------------------------------------------
// mp_add_seq16
//    Sequential multi-precision adder/subtractor. Operands arrive one 16-bit
//    word pair per handshake, least-significant word first. This block does
//    not contain the adder. It drives an external 16-bit ripple adder,
//    chains that adder's carry from word to word, and registers each result
//    word behind a valid/ready output stage. The stage sustains one word per
//    cycle.
//
// Ports
//    clk, rst_n        clock, asynchronous active-low reset
//    in_valid/in_ready operand word handshake
//    in_a, in_b        operand words (A and B)
//    in_first/in_last  operand framing (least / most significant word)
//    in_sub            1 = A-B, 0 = A+B (taken from the first word only)
//    add_a/add_b/add_cin   operands driven to the external adder
//    add_sum/add_cout      result returned by the external adder
//    out_valid/out_ready   result word handshake
//    out_sum, out_carry    result word and its carry (sub: 1 = no borrow)
//    out_last, out_idx     framing of the result word
//    seq_err               one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module mp_add_seq16 #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic             in_first,
   input  logic             in_last,
   input  logic             in_sub,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   output logic             add_cin,
   input  logic [15:0]      add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_sum,
   output logic             out_carry,
   output logic             out_last,
   output logic [CNT_W-1:0] out_idx,
   output logic             seq_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic               out_valid_q;
   logic [15:0]        out_sum_q;
   logic               out_carry_q;
   logic               out_last_q;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic               seq_err_q, seq_err_d;
   logic               carry_q;
   logic               sub_q;

   logic               accept;
   logic               firstEff;
   logic               subEff;

   // The output register can take a new word when it is empty or is being
   // emptied in this same cycle. That allows full throughput.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // In IDLE, any word starts a new operand, even if in_first is missing.
   assign firstEff = in_first || (state_q == IDLE);
   assign subEff   = firstEff ? in_sub : sub_q;

   // The adder is fed whether or not in_valid is high. The registers only
   // capture its result on an accept. For subtraction, A-B is computed as
   // A + ~B + 1, so the first word injects the +1 through the carry input.
   assign add_a   = in_a;
   assign add_b   = subEff ? ~in_b : in_b;
   assign add_cin = firstEff ? subEff : carry_q;

   // Next-state values. A framing error is a first-word marker whose
   // presence disagrees with the current state.
   assign idx_d     = firstEff ? '0 : idx_q + CNT_W'(1);
   assign state_d   = in_last ? IDLE : BUSY;
   assign seq_err_d = accept && (in_first == (state_q == BUSY));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_carry_q <= 1'b0;
         out_last_q  <= 1'b0;
         idx_q       <= '0;
         seq_err_q   <= 1'b0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
      end else begin
         seq_err_q <= seq_err_d;
         if (accept) begin
            state_q     <= state_d;
            out_valid_q <= 1'b1;
            out_sum_q   <= add_sum;
            out_carry_q <= add_cout;
            out_last_q  <= in_last;
            idx_q       <= idx_d;
            carry_q     <= add_cout;
            sub_q       <= subEff;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_carry = out_carry_q;
   assign out_last  = out_last_q;
   assign out_idx   = idx_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_mp_add_seq16.sv
// ---------------------------------------------------------------------------
// tb_mp_add_seq16
//    Directed testbench for mp_add_seq16. It models the external 16-bit
//    ripple adder. Each word the stimulus issues has a hand-computed expected
//    result, which is pushed into a scoreboard queue. A separate monitor
//    process compares every presented output word against the head of that
//    queue.
// ---------------------------------------------------------------------------
module tb_mp_add_seq16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        in_first = 1'b0;
   logic        in_last = 1'b0;
   logic        in_sub = 1'b0;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_cout;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_sum;
   logic        out_carry;
   logic        out_last;
   logic [3:0]  out_idx;
   logic        seq_err;

   typedef struct packed {
      logic [15:0] sum;
      logic        carry;
      logic        last;
      logic [3:0]  idx;
      logic        err;
   } exp_t;

   exp_t sbQ[$];
   int   nCompared = 0;
   int   nMismatch = 0;

   mp_add_seq16 #(.CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_sub    (in_sub),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_last  (out_last),
      .out_idx   (out_idx),
      .seq_err   (seq_err)
   );

   // Model of the external 16-bit adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one word pair, checks the carry input the DUT hands to the adder,
   // records the expected result, and waits (bounded) for the word to be accepted.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic first, input logic last, input logic sub,
                                input logic expCin, input logic [15:0] expSum,
                                input logic expCarry, input logic [3:0] expIdx,
                                input logic expErr, input bit track);
      bit   accepted = 1'b0;
      exp_t e;
      in_a     = a;
      in_b     = b;
      in_first = first;
      in_last  = last;
      in_sub   = sub;
      in_valid = 1'b1;
      #1;
      checkOutput("add_cin", {31'd0, add_cin}, {31'd0, expCin});
      e.sum   = expSum;
      e.carry = expCarry;
      e.last  = last;
      e.idx   = expIdx;
      e.err   = expErr;
      if (track) sbQ.push_back(e);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) begin
         nCompared++;
         nMismatch++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 20 cycles");
         if (track) void'(sbQ.pop_back());
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drainQueue();
      for (int c = 0; c < 50; c++) begin
         if (sbQ.size() == 0) break;
         @(negedge clk);
      end
      if (sbQ.size() != 0) begin
         nCompared++;
         nMismatch++;
         $display("[TB] FAIL drain_timeout: %0d words outstanding, expected 0", sbQ.size());
         sbQ.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState();
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_sum",   {16'd0, out_sum},   32'd0);
      checkOutput("rst_out_carry", {31'd0, out_carry}, 32'd0);
      checkOutput("rst_out_last",  {31'd0, out_last},  32'd0);
      checkOutput("rst_out_idx",   {28'd0, out_idx},   32'd0);
      checkOutput("rst_seq_err",   {31'd0, seq_err},   32'd0);
      checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
   endtask

   // Monitor: compares every presented word against the scoreboard head.
   // While stalled, the same expectation is rechecked each cycle, which
   // covers output stability. seq_err is gathered while a word is on offer
   // and checked once when that word is handed off.
   initial begin : monitor
      bit   errSticky = 1'b0;
      bit   prevErr   = 1'b0;
      exp_t f;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            errSticky = 1'b0;
            prevErr   = 1'b0;
         end else begin
            if (prevErr) checkOutput("seq_err_width", {31'd0, seq_err}, 32'd0);
            prevErr   = seq_err;
            errSticky = errSticky | seq_err;
            if (out_valid) begin
               if (sbQ.size() == 0) begin
                  nCompared++;
                  nMismatch++;
                  $display("[TB] FAIL unexpected_output: got sum 0x%0h idx %0d, expected no word", out_sum, out_idx);
               end else begin
                  f = sbQ[0];
                  checkOutput("out_word", {10'd0, out_sum, out_carry, out_last, out_idx},
                              {10'd0, f.sum, f.carry, f.last, f.idx});
                  if (out_ready) begin
                     checkOutput("seq_err", {31'd0, errSticky}, {31'd0, f.err});
                     errSticky = 1'b0;
                     void'(sbQ.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin : stimulus
      #1 rst_n = 1'b0;
      #1 checkResetState();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single-word add: FFFF + 0001 = 0000, carry 1.
      applyStimulus(16'hFFFF, 16'h0001, 1, 1, 0, 0, 16'h0000, 1, 4'd0, 0, 1);

      // Two-word add with a carry chained into the upper word.
      applyStimulus(16'hFFFF, 16'h0001, 1, 0, 0, 0, 16'h0000, 1, 4'd0, 0, 1);
      applyStimulus(16'h0001, 16'h0000, 0, 1, 0, 1, 16'h0002, 0, 4'd1, 0, 1);

      // Single-word subtract: 5 - 7 = FFFE with borrow (carry 0).
      applyStimulus(16'h0005, 16'h0007, 1, 1, 1, 1, 16'hFFFE, 0, 4'd0, 0, 1);

      // Two-word subtract 0x0001_0000 - 0x0000_0001 = 0x0000_FFFF. The
      // upper word drives in_sub=0, so it must use the latched operation.
      applyStimulus(16'h0000, 16'h0001, 1, 0, 1, 1, 16'hFFFF, 0, 4'd0, 0, 1);
      applyStimulus(16'h0001, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 4'd1, 0, 1);
      drainQueue();

      // Four-word stream with out_ready held low for three cycles.
      fork
         begin
            applyStimulus(16'h1234, 16'h1111, 1, 0, 0, 0, 16'h2345, 0, 4'd0, 0, 1);
            applyStimulus(16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 4'd1, 0, 1);
            applyStimulus(16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0001, 0, 4'd2, 0, 1);
            applyStimulus(16'h8000, 16'h8000, 0, 1, 0, 0, 16'h0000, 1, 4'd3, 0, 1);
         end
         begin
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               checkOutput("in_ready_stall", {31'd0, in_ready}, 32'd0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drainQueue();

      // Framing error in IDLE: a word without in_first is taken as first.
      // carry_q is 1 here, so add_cin must come from in_sub (0).
      applyStimulus(16'h0003, 16'h0004, 0, 1, 0, 0, 16'h0007, 0, 4'd0, 1, 1);

      // Framing error in BUSY: in_first restarts the operand at index 0.
      applyStimulus(16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 16'hFFFE, 1, 4'd0, 0, 1);
      applyStimulus(16'h0010, 16'h0003, 1, 0, 0, 0, 16'h0013, 0, 4'd0, 1, 1);
      applyStimulus(16'h0001, 16'h0001, 0, 1, 0, 0, 16'h0002, 0, 4'd1, 0, 1);
      drainQueue();

      // Seventeen-word operand: the index wraps from 15 back to 0 silently.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(16'(i), 16'h0000, (i == 0), (i == 16), 0, 0, 16'(i), 0, 4'(i % 16), 0, 1);
      end
      drainQueue();

      // Reset after word 0 of a three-word operand. Word 0 is never delivered.
      applyStimulus(16'h1111, 16'h2222, 1, 0, 0, 0, 16'h3333, 0, 4'd0, 0, 0);
      rst_n = 1'b0;
      #1 checkResetState();
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(16'h0005, 16'h0003, 1, 0, 1, 1, 16'h0002, 1, 4'd0, 0, 1);
      applyStimulus(16'h0001, 16'h0000, 0, 1, 0, 1, 16'h0001, 1, 4'd1, 0, 1);
      drainQueue();

      checkOutput("queue_empty", sbQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch + 1);
      $fatal(1, "[TB] timeout");
   end

endmodule
